button_debounce: RTL

- Input-side companion to the constant-output demo blocks: conditions a raw, bouncy board input (pushbutton or slide switch) into a clean level, one-cycle edge pulses and a press count.
- Debounce interval is selected at compile time with the `ifdef SIM directive: short for simulation, long (about 10 ms) for synthesis.
- Sits between a board input pin and any FSM or counter logic that consumes user input.

---
 rtl/button_debounce.sv | 139 +++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// button_debounce: conditions a raw, bouncy board input into a clean level,
// one-cycle rise/fall pulses and a wrapping 8-bit press count.
module button_debounce #(
    parameter int unsigned SIM_TICKS = 4,
    parameter int unsigned SYN_TICKS = 500000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       btn_db,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [7:0] press_cnt
);

    // Debounce interval; must be at least 2 and fit in CNT_W bits.
`ifdef SIM
    localparam int unsigned DEBOUNCE_TICKS = SIM_TICKS;
`else
    localparam int unsigned DEBOUNCE_TICKS = SYN_TICKS;
`endif

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sync1;
    logic             sync2;
    logic             db_next;
    logic             rise_next;
    logic             fall_next;
    logic [7:0]       press_next;

    // Two-flop synchronizer for the asynchronous board input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // State, stability counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= STABLE_LO;
            cnt       <= '0;
            btn_db    <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            busy      <= 1'b0;
            press_cnt <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            btn_db    <= db_next;
            rise      <= rise_next;
            fall      <= fall_next;
            busy      <= (state_next == WAIT_HI) || (state_next == WAIT_LO);
            press_cnt <= press_next;
        end
    end

    // Next-state logic: qualify N consecutive samples at the new level.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        db_next    = btn_db;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        press_next = press_cnt;
        unique case (state)
            STABLE_LO: begin
                db_next = 1'b0;
                if (sync2) begin
                    state_next = WAIT_HI;
                    cnt_next   = ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT_HI: begin
                if (!sync2) begin
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                end else if (cnt == LAST_TICK) begin
                    state_next = STABLE_HI;
                    cnt_next   = '0;
                    db_next    = 1'b1;
                    rise_next  = 1'b1;
                    press_next = press_cnt + 8'd1;
                end else begin
                    cnt_next = cnt + ONE;
                end
            end
            STABLE_HI: begin
                db_next = 1'b1;
                if (!sync2) begin
                    state_next = WAIT_LO;
                    cnt_next   = ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT_LO: begin
                if (sync2) begin
                    state_next = STABLE_HI;
                    cnt_next   = '0;
                end else if (cnt == LAST_TICK) begin
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                    db_next    = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt + ONE;
                end
            end
            default: begin
                state_next = STABLE_LO;
                cnt_next   = '0;
            end
        endcase
    end

endmodule
